// File: rtl/i2c_pkg.sv
// i2c_pkg: shared types and constants for the I2C target engine.
//   state_e    : slave FSM states
//   BUSY..NACK : bit positions inside the status byte
//   IDLE_BYTE  : value shifted out when a read finds the TX FIFO empty
package i2c_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        RX_DATA,
        RX_ACK,
        TX_DATA,
        TX_ACK,
        WAIT_STOP
    } state_e;

    localparam int BUSY   = 0;
    localparam int RW     = 1;
    localparam int RX_OVF = 2;
    localparam int NACK   = 3;

    localparam logic [7:0] IDLE_BYTE = 8'hFF;

endpackage

// File: rtl/i2c_line_sync.sv
// i2c_line_sync: brings the asynchronous SCL/SDA pins into the core clock
// domain and derives single-cycle bus event strobes.
//   clk, rst_n      : core clock, asynchronous active-low reset
//   scl_i, sda_i    : raw bus lines
//   sda             : synchronised SDA level
//   scl_rise/fall   : SCL edge strobes
//   start / stop    : SDA fall / rise while SCL is high
// Synchronisers reset to 1 (idle bus) so reset release produces no edge.
module i2c_line_sync
    import i2c_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start,
    output logic stop
);

    logic [SYNC_STAGES-1:0] scl_sync_p0;
    logic [SYNC_STAGES-1:0] sda_sync_p0;
    logic                   scl_p1;
    logic                   sda_p1;
    logic                   scl;

    // stage 0: metastability synchronisers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync_p0 <= '1;
            sda_sync_p0 <= '1;
        end else begin
            scl_sync_p0 <= {scl_sync_p0[SYNC_STAGES-2:0], scl_i};
            sda_sync_p0 <= {sda_sync_p0[SYNC_STAGES-2:0], sda_i};
        end
    end

    assign scl = scl_sync_p0[SYNC_STAGES-1];
    assign sda = sda_sync_p0[SYNC_STAGES-1];

    // stage 1: previous-sample register for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_p1 <= 1'b1;
            sda_p1 <= 1'b1;
        end else begin
            scl_p1 <= scl;
            sda_p1 <= sda;
        end
    end

    // SCL must be high on both samples so an SDA change that races an
    // SCL edge is never mistaken for START/STOP.
    assign scl_rise = scl & ~scl_p1;
    assign scl_fall = ~scl & scl_p1;
    assign start    = scl & scl_p1 & sda_p1 & ~sda;
    assign stop     = scl & scl_p1 & ~sda_p1 & sda;

endmodule

// File: rtl/i2c_slave_fsm.sv
// i2c_slave_fsm: I2C target engine (no clock stretching, open drain).
//   i2c_core_clk_i, reset_ni : core clock (>= 8x SCL), async active-low reset
//   enable_i                 : low forces IDLE and releases SDA
//   slave_addr_i             : own 7-bit address
//   i2c_scl_i, i2c_sda_i     : bus lines
//   i2c_sda_o, i2c_sda_en_o  : open-drain SDA (value tied 0, enable = pull low)
//   data_transmit_i, tx_empty_i, r_fifo_en_o     : TX FIFO head / empty / pop
//   data_receive_o, rx_full_i, w_fifo_en_o       : RX FIFO data / full / push
//   stop_o                   : pulse on STOP after this slave was addressed
//   status_o                 : {4'b0, nack_seen, rx_overflow, rw, busy}
module i2c_slave_fsm
    import i2c_pkg::*;
#(
    parameter int DATA_SIZE   = 8,
    parameter int ADDR_SIZE   = 7,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 i2c_core_clk_i,
    input  logic                 reset_ni,
    input  logic                 enable_i,
    input  logic [ADDR_SIZE-1:0] slave_addr_i,
    input  logic                 i2c_scl_i,
    input  logic                 i2c_sda_i,
    output logic                 i2c_sda_o,
    output logic                 i2c_sda_en_o,
    input  logic [DATA_SIZE-1:0] data_transmit_i,
    input  logic                 tx_empty_i,
    output logic                 r_fifo_en_o,
    output logic [DATA_SIZE-1:0] data_receive_o,
    input  logic                 rx_full_i,
    output logic                 w_fifo_en_o,
    output logic                 stop_o,
    output logic [7:0]           status_o
);

    localparam int                   CNT_W    = $clog2(DATA_SIZE) + 1;
    localparam logic [CNT_W-1:0]     CNT_TOP  = CNT_W'(DATA_SIZE - 1);
    // All-ones marks "byte complete, waiting for the closing SCL fall".
    localparam logic [CNT_W-1:0]     CNT_DONE = '1;
    localparam logic [DATA_SIZE-1:0] TX_IDLE  = DATA_SIZE'(IDLE_BYTE);

    logic sda;
    logic scl_rise;
    logic scl_fall;
    logic start_s;
    logic stop_s;

    state_e               state;
    state_e               state_nxt;
    logic [CNT_W-1:0]     bit_cnt;
    logic [CNT_W-1:0]     cnt_nxt;
    logic [DATA_SIZE-1:0] shift_reg;
    logic [DATA_SIZE-1:0] shift_nxt;
    logic [DATA_SIZE-1:0] shift_in;
    logic [DATA_SIZE-1:0] tx_sr;
    logic [DATA_SIZE-1:0] tx_nxt;
    logic [DATA_SIZE-1:0] tx_byte;
    logic [DATA_SIZE-1:0] data_rx_q;

    logic busy;
    logic rw;
    logic rx_ovf;
    logic nack_seen;

    logic sda_en_q;
    logic sda_en_nxt;
    logic r_pop_q;
    logic r_pop_nxt;
    logic w_push_q;
    logic w_push_nxt;
    logic stop_q;
    logic stop_nxt;

    // decoded per-cycle actions from the next-state logic
    logic addr_hit;
    logic ack_drive;
    logic load_tx;
    logic tx_shift;
    logic push_rx;
    logic ovf_set;
    logic nack_set;
    logic sda_release;

    i2c_line_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_line_sync (
        .clk      (i2c_core_clk_i),
        .rst_n    (reset_ni),
        .scl_i    (i2c_scl_i),
        .sda_i    (i2c_sda_i),
        .sda      (sda),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start    (start_s),
        .stop     (stop_s)
    );

    assign shift_in = {shift_reg[DATA_SIZE-2:0], sda};
    assign tx_byte  = tx_empty_i ? TX_IDLE : data_transmit_i;

    // State register
    always_ff @(posedge i2c_core_clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and datapath-next logic. Bus events override any SCL-fall
    // action, so no FIFO strobe or SDA drive can occur alongside them.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = bit_cnt;
        shift_nxt   = shift_reg;
        tx_nxt      = tx_sr;
        addr_hit    = 1'b0;
        ack_drive   = 1'b0;
        load_tx     = 1'b0;
        tx_shift    = 1'b0;
        push_rx     = 1'b0;
        ovf_set     = 1'b0;
        nack_set    = 1'b0;
        sda_release = 1'b0;

        if (!enable_i || stop_s) begin
            state_nxt = IDLE;
        end else if (start_s) begin
            state_nxt = ADDR;
            cnt_nxt   = CNT_TOP;
        end else begin
            unique case (state)
                IDLE, WAIT_STOP: begin
                    sda_release = 1'b1;
                end
                ADDR: begin
                    if (scl_rise && bit_cnt != CNT_DONE) begin
                        shift_nxt = shift_in;
                        if (bit_cnt == '0) begin
                            cnt_nxt = CNT_DONE;
                            if (shift_in[ADDR_SIZE:1] == slave_addr_i) begin
                                addr_hit = 1'b1;
                            end else begin
                                state_nxt = WAIT_STOP;
                            end
                        end else begin
                            cnt_nxt = bit_cnt - CNT_W'(1);
                        end
                    end else if (scl_fall && bit_cnt == CNT_DONE) begin
                        state_nxt = ADDR_ACK;
                        ack_drive = 1'b1;
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        if (rw) begin
                            load_tx   = 1'b1;
                            tx_nxt    = tx_byte;
                            cnt_nxt   = CNT_TOP;
                            state_nxt = TX_DATA;
                        end else begin
                            sda_release = 1'b1;
                            cnt_nxt     = CNT_TOP;
                            state_nxt   = RX_DATA;
                        end
                    end
                end
                RX_DATA: begin
                    if (scl_rise && bit_cnt != CNT_DONE) begin
                        shift_nxt = shift_in;
                        cnt_nxt   = (bit_cnt == '0) ? CNT_DONE : bit_cnt - CNT_W'(1);
                    end else if (scl_fall && bit_cnt == CNT_DONE) begin
                        state_nxt = RX_ACK;
                        if (!rx_full_i) begin
                            push_rx = 1'b1;
                        end else begin
                            ovf_set = 1'b1;
                        end
                    end
                end
                RX_ACK: begin
                    // The SDA enable still held here records whether we ACKed.
                    if (scl_fall) begin
                        sda_release = 1'b1;
                        if (sda_en_q) begin
                            cnt_nxt   = CNT_TOP;
                            state_nxt = RX_DATA;
                        end else begin
                            state_nxt = WAIT_STOP;
                        end
                    end
                end
                TX_DATA: begin
                    if (scl_fall) begin
                        if (bit_cnt == '0) begin
                            sda_release = 1'b1;
                            state_nxt   = TX_ACK;
                        end else begin
                            tx_shift = 1'b1;
                            tx_nxt   = {tx_sr[DATA_SIZE-2:0], 1'b0};
                            cnt_nxt  = bit_cnt - CNT_W'(1);
                        end
                    end
                end
                TX_ACK: begin
                    // bit_cnt == 0: waiting for the master's ACK bit;
                    // CNT_DONE: ACK seen, next byte loads on the SCL fall.
                    if (scl_rise && bit_cnt == '0) begin
                        if (sda) begin
                            nack_set  = 1'b1;
                            state_nxt = WAIT_STOP;
                        end else begin
                            cnt_nxt = CNT_DONE;
                        end
                    end else if (scl_fall && bit_cnt == CNT_DONE) begin
                        load_tx   = 1'b1;
                        tx_nxt    = tx_byte;
                        cnt_nxt   = CNT_TOP;
                        state_nxt = TX_DATA;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    // Output logic: next values of the registered bus/FIFO outputs
    always_comb begin
        sda_en_nxt = sda_en_q;
        r_pop_nxt  = 1'b0;
        w_push_nxt = 1'b0;
        stop_nxt   = 1'b0;

        if (!enable_i) begin
            sda_en_nxt = 1'b0;
        end else if (stop_s) begin
            sda_en_nxt = 1'b0;
            stop_nxt   = busy;
        end else if (start_s) begin
            sda_en_nxt = 1'b0;
        end else begin
            if (ack_drive || push_rx) begin
                sda_en_nxt = 1'b1;
            end
            if (sda_release || ovf_set) begin
                sda_en_nxt = 1'b0;
            end
            if (load_tx) begin
                sda_en_nxt = ~tx_byte[DATA_SIZE-1];
                r_pop_nxt  = ~tx_empty_i;
            end
            if (tx_shift) begin
                sda_en_nxt = ~tx_sr[DATA_SIZE-2];
            end
            w_push_nxt = push_rx;
        end
    end

    // Datapath, flags and registered outputs
    always_ff @(posedge i2c_core_clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            bit_cnt   <= '0;
            shift_reg <= '0;
            tx_sr     <= '0;
            data_rx_q <= '0;
            busy      <= 1'b0;
            rw        <= 1'b0;
            rx_ovf    <= 1'b0;
            nack_seen <= 1'b0;
            sda_en_q  <= 1'b0;
            r_pop_q   <= 1'b0;
            w_push_q  <= 1'b0;
            stop_q    <= 1'b0;
        end else begin
            bit_cnt   <= cnt_nxt;
            shift_reg <= shift_nxt;
            tx_sr     <= tx_nxt;
            sda_en_q  <= sda_en_nxt;
            r_pop_q   <= r_pop_nxt;
            w_push_q  <= w_push_nxt;
            stop_q    <= stop_nxt;

            if (push_rx) begin
                data_rx_q <= shift_reg;
            end

            if (!enable_i || stop_s || start_s) begin
                busy <= 1'b0;
                rw   <= 1'b0;
            end else if (addr_hit) begin
                busy <= 1'b1;
                rw   <= shift_in[0];
            end

            // Error flags survive STOP so software can read them afterwards.
            if (enable_i && !stop_s && start_s) begin
                rx_ovf    <= 1'b0;
                nack_seen <= 1'b0;
            end else begin
                if (ovf_set) begin
                    rx_ovf <= 1'b1;
                end
                if (nack_set) begin
                    nack_seen <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        status_o         = '0;
        status_o[BUSY]   = busy;
        status_o[RW]     = rw;
        status_o[RX_OVF] = rx_ovf;
        status_o[NACK]   = nack_seen;
    end

    assign i2c_sda_o      = 1'b0;
    assign i2c_sda_en_o   = sda_en_q;
    assign r_fifo_en_o    = r_pop_q;
    assign w_fifo_en_o    = w_push_q;
    assign data_receive_o = data_rx_q;
    assign stop_o         = stop_q;

endmodule

// File: tb/tb_i2c_slave_fsm.sv
// Testbench for i2c_slave_fsm: bus-level master model driving write
// transactions from a vector table, plus directed read, empty-FIFO,
// repeated-START and mid-transfer reset sequences.
module tb_i2c_slave_fsm;

    localparam int Q = 10;  // core cycles per quarter SCL period

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_ni;
    logic       enable;
    logic [6:0] slave_addr;
    logic       scl_m;
    logic       sda_m;
    logic       sda_line;
    logic       sda_o;
    logic       sda_en;
    logic [7:0] data_tx;
    logic       tx_empty;
    logic       r_en;
    logic [7:0] data_rx;
    logic       rx_full;
    logic       w_en;
    logic       stop_p;
    logic [7:0] status;

    // open-drain bus: either side can pull SDA low
    assign sda_line = sda_m & ~sda_en;

    i2c_slave_fsm dut (
        .i2c_core_clk_i  (clk),
        .reset_ni        (reset_ni),
        .enable_i        (enable),
        .slave_addr_i    (slave_addr),
        .i2c_scl_i       (scl_m),
        .i2c_sda_i       (sda_line),
        .i2c_sda_o       (sda_o),
        .i2c_sda_en_o    (sda_en),
        .data_transmit_i (data_tx),
        .tx_empty_i      (tx_empty),
        .r_fifo_en_o     (r_en),
        .data_receive_o  (data_rx),
        .rx_full_i       (rx_full),
        .w_fifo_en_o     (w_en),
        .stop_o          (stop_p),
        .status_o        (status)
    );

    // TX FIFO model and strobe monitors
    logic [7:0] tx_mem [8];
    int         tx_avail = 0;
    int         pop_cnt  = 0;
    int         push_cnt = 0;
    int         stop_cnt = 0;
    int         en_cnt   = 0;
    logic [7:0] last_rx  = 8'h00;

    assign data_tx  = tx_mem[pop_cnt[2:0]];
    assign tx_empty = (pop_cnt >= tx_avail);

    always @(posedge clk) begin
        if (w_en) begin
            push_cnt <= push_cnt + 1;
            last_rx  <= data_rx;
        end
        if (r_en)   pop_cnt  <= pop_cnt + 1;
        if (stop_p) stop_cnt <= stop_cnt + 1;
        if (sda_en) en_cnt   <= en_cnt + 1;
    end

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic qwait();
        repeat (Q) @(posedge clk);
        #2;
    endtask

    task automatic i2c_start();
        sda_m = 1'b0; qwait();
        scl_m = 1'b0; qwait();
    endtask

    task automatic i2c_rstart();
        sda_m = 1'b1; qwait();
        scl_m = 1'b1; qwait();
        sda_m = 1'b0; qwait();
        scl_m = 1'b0; qwait();
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; qwait();
        scl_m = 1'b1; qwait();
        sda_m = 1'b1; qwait();
    endtask

    task automatic write_bit(input logic b);
        sda_m = b;    qwait();
        scl_m = 1'b1; qwait(); qwait();
        scl_m = 1'b0; qwait();
    endtask

    task automatic read_bit(output logic b);
        sda_m = 1'b1; qwait();
        scl_m = 1'b1; qwait();
        b = sda_line; qwait();
        scl_m = 1'b0; qwait();
    endtask

    task automatic write_byte(input logic [7:0] v, output logic ack);
        for (int i = 7; i >= 0; i--) write_bit(v[i]);
        read_bit(ack);
    endtask

    task automatic read_byte(output logic [7:0] v, input logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            v[i] = b;
        end
        write_bit(ack);
    endtask

    typedef struct {
        logic [7:0] addr_byte;
        logic [7:0] data;
        logic       full;
        logic       exp_aack;    // line level in address ACK slot
        logic       exp_dack;    // line level in data ACK slot
        logic [7:0] exp_mid;     // status after the address byte
        int         exp_push;
        logic [7:0] exp_rx;
        int         exp_stop;
        int         exp_en;      // 1 if the slave should ever pull SDA
        logic [7:0] exp_status;  // status after STOP
    } wvec_t;

    wvec_t wv [6];

    task automatic apply_wvec(input wvec_t v, input int idx);
        int   p0, s0, e0;
        logic ack;
        p0 = push_cnt; s0 = stop_cnt; e0 = en_cnt;
        rx_full = v.full;
        i2c_start();
        write_byte(v.addr_byte, ack);
        check($sformatf("v%0d_addr_ack", idx), 32'(ack), 32'(v.exp_aack));
        check($sformatf("v%0d_status_mid", idx), 32'(status), 32'(v.exp_mid));
        write_byte(v.data, ack);
        check($sformatf("v%0d_data_ack", idx), 32'(ack), 32'(v.exp_dack));
        i2c_stop();
        qwait();
        check($sformatf("v%0d_pushes", idx), push_cnt - p0, v.exp_push);
        check($sformatf("v%0d_stop_pulses", idx), stop_cnt - s0, v.exp_stop);
        check($sformatf("v%0d_sda_driven", idx), 32'(en_cnt != e0), v.exp_en);
        check($sformatf("v%0d_status_end", idx), 32'(status), 32'(v.exp_status));
        if (v.exp_push != 0)
            check($sformatf("v%0d_rx_byte", idx), 32'(last_rx), 32'(v.exp_rx));
        rx_full = 1'b0;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic       ack;
        logic [7:0] b;
        int         p0, u0, s0;

        //            addr   data   full aack dack mid    push rx     stop en status
        wv[0] = '{8'h78, 8'hA5, 1'b0, 1'b0, 1'b0, 8'h01, 1, 8'hA5, 1, 1, 8'h00};
        wv[1] = '{8'h78, 8'h3C, 1'b0, 1'b0, 1'b0, 8'h01, 1, 8'h3C, 1, 1, 8'h00};
        wv[2] = '{8'h7A, 8'h11, 1'b0, 1'b1, 1'b1, 8'h00, 0, 8'h00, 0, 0, 8'h00};
        wv[3] = '{8'h78, 8'h55, 1'b1, 1'b0, 1'b1, 8'h01, 0, 8'h00, 1, 1, 8'h04};
        wv[4] = '{8'h00, 8'hFF, 1'b0, 1'b1, 1'b1, 8'h00, 0, 8'h00, 0, 0, 8'h00};
        wv[5] = '{8'h78, 8'h00, 1'b0, 1'b0, 1'b0, 8'h01, 1, 8'h00, 1, 1, 8'h00};

        for (int i = 0; i < 8; i++) tx_mem[i] = 8'h00;
        reset_ni   = 1'b0;
        enable     = 1'b1;
        slave_addr = 7'h3C;
        scl_m      = 1'b1;
        sda_m      = 1'b1;
        rx_full    = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        check("reset_sda_en",  32'(sda_en),  32'h0);
        check("reset_r_fifo",  32'(r_en),    32'h0);
        check("reset_w_fifo",  32'(w_en),    32'h0);
        check("reset_stop",    32'(stop_p),  32'h0);
        check("reset_rx_data", 32'(data_rx), 32'h0);
        check("reset_status",  32'(status),  32'h0);
        check("reset_sda_o",   32'(sda_o),   32'h0);
        reset_ni = 1'b1;
        qwait();

        for (int i = 0; i < 6; i++) apply_wvec(wv[i], i);

        // read two bytes: ACK the first, NACK the second
        p0 = pop_cnt; s0 = stop_cnt;
        tx_mem[3'(p0 % 8)]       = 8'h5A;
        tx_mem[3'((p0 + 1) % 8)] = 8'hC3;
        tx_avail = p0 + 2;
        i2c_start();
        write_byte(8'h79, ack);
        check("rd_addr_ack", 32'(ack), 32'h0);
        check("rd_status_busy", 32'(status), 32'h03);
        read_byte(b, 1'b0);
        check("rd_byte0", 32'(b), 32'h5A);
        read_byte(b, 1'b1);
        check("rd_byte1", 32'(b), 32'hC3);
        check("rd_status_nack", 32'(status), 32'h0B);
        i2c_stop();
        qwait();
        check("rd_pops", pop_cnt - p0, 2);
        check("rd_stop_pulses", stop_cnt - s0, 1);
        check("rd_status_end", 32'(status), 32'h08);

        // read with the TX FIFO empty: idle byte, no pop
        p0 = pop_cnt;
        tx_avail = p0;
        i2c_start();
        write_byte(8'h79, ack);
        check("empty_addr_ack", 32'(ack), 32'h0);
        read_byte(b, 1'b1);
        check("empty_byte", 32'(b), 32'hFF);
        i2c_stop();
        qwait();
        check("empty_pops", pop_cnt - p0, 0);
        check("empty_status_end", 32'(status), 32'h08);

        // write, repeated START, read one byte
        p0 = pop_cnt; u0 = push_cnt; s0 = stop_cnt;
        tx_mem[3'(p0 % 8)] = 8'h96;
        tx_avail = p0 + 1;
        i2c_start();
        write_byte(8'h78, ack);
        check("sr_waddr_ack", 32'(ack), 32'h0);
        write_byte(8'h01, ack);
        check("sr_wdata_ack", 32'(ack), 32'h0);
        i2c_rstart();
        check("sr_no_stop_at_sr", stop_cnt - s0, 0);
        write_byte(8'h79, ack);
        check("sr_raddr_ack", 32'(ack), 32'h0);
        check("sr_status_read", 32'(status), 32'h03);
        read_byte(b, 1'b1);
        check("sr_rd_byte", 32'(b), 32'h96);
        i2c_stop();
        qwait();
        check("sr_pushes", push_cnt - u0, 1);
        check("sr_rx_byte", 32'(last_rx), 32'h01);
        check("sr_pops", pop_cnt - p0, 1);
        check("sr_stop_pulses", stop_cnt - s0, 1);

        // reset while the slave is driving a 0 data bit
        p0 = pop_cnt; s0 = stop_cnt;
        tx_mem[3'(p0 % 8)] = 8'h5A;
        tx_avail = p0 + 1;
        i2c_start();
        write_byte(8'h79, ack);
        check("rst_addr_ack", 32'(ack), 32'h0);
        check("rst_driving_low", 32'(sda_en), 32'h1);
        @(posedge clk);
        #3 reset_ni = 1'b0;
        #1;
        check("rst_async_release", 32'(sda_en), 32'h0);
        check("rst_status", 32'(status), 32'h0);
        i2c_stop();
        reset_ni = 1'b1;
        qwait();
        check("rst_no_stop_pulse", stop_cnt - s0, 0);
        apply_wvec(wv[0], 99);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
